rr_onehot_arbiter: RTL



---
 rtl/rr_onehot_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: registered round-robin arbiter with one-hot grant and hold limit
// Ports:
//   clk         - clock, all state updates on the rising edge
//   rst         - synchronous active-high reset
//   req         - request lines, bit i = requester i
//   grant       - registered grant, one-hot or all-zero
//   grant_valid - registered, equals |grant
//   grant_new   - registered pulse in the first cycle of every new grant (re-grants too)
module rr_onehot_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] grant,
    output logic             grant_valid,
    output logic             grant_new
);
    localparam int PW = $clog2(WIDTH);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t              r_state;
    logic [PW-1:0]       r_ptr;
    logic [HW-1:0]       r_hold;
    logic [2*WIDTH-1:0]  w_dbl;
    logic [WIDTH-1:0]    w_rot;
    logic [PW-1:0]       w_win;
    logic [PW-1:0]       w_next_ptr;
    logic [HW-1:0]       w_hold_init;
    logic [HW-1:0]       w_hold_inc;
    logic                w_found;
    logic                w_held;
    logic                w_expire;
    logic                w_take;
    int                  w_off;
    int                  w_sum;

    // Rotate requests so that bit 0 is the pointer position, then take the lowest set bit.
    // While g is held, ptr == g+1, so scanning the full req on expiry visits every other
    // requester before wrapping back to g: a lone holder is naturally re-granted.
    always_comb begin
        w_dbl   = {req, req} >> r_ptr;
        w_rot   = w_dbl[WIDTH-1:0];
        w_found = 1'b0;
        w_off   = 0;
        for (int k = 0; k < WIDTH; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_off   = k;
            end
        end
        w_sum       = int'(r_ptr) + w_off;
        w_win       = PW'((w_sum >= WIDTH) ? w_sum - WIDTH : w_sum);
        w_next_ptr  = (w_win == PW'(WIDTH - 1)) ? '0 : w_win + PW'(1);
        w_held      = |(req & grant);
        w_expire    = (MAX_HOLD != 0) && (r_hold == HW'(MAX_HOLD)) && w_held;
        w_take      = w_found && (!w_held || w_expire);
        w_hold_init = (MAX_HOLD != 0) ? HW'(1) : '0;
        w_hold_inc  = (MAX_HOLD == 0 || r_hold == HW'(MAX_HOLD)) ? r_hold : r_hold + HW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_new   <= 1'b0;
            r_ptr       <= '0;
            r_hold      <= '0;
        end else if (!w_found) begin
            r_state     <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_new   <= 1'b0;
            r_hold      <= '0;
        end else if (r_state == IDLE || w_take) begin
            r_state     <= GRANTED;
            grant       <= WIDTH'(1) << w_win;
            grant_valid <= 1'b1;
            grant_new   <= 1'b1;
            r_ptr       <= w_next_ptr;
            r_hold      <= w_hold_init;
        end else begin
            grant_new   <= 1'b0;
            r_hold      <= w_hold_inc;
        end
    end
endmodule
